// File: rtl/neuron_vector_loader.sv
// rtl/neuron_vector_loader.sv - double-buffered fp32 stream-to-vector loader for neuron_inputNN
module neuron_vector_loader #(
  parameter int N_INPUTS    = 37,
  parameter int DATA_W      = 32,
  parameter int HOLD_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic [DATA_W-1:0] vec_out [N_INPUTS],
  output logic              vec_valid,
  output logic              frame_err
);

  localparam int ADDR_W = $clog2(N_INPUTS);
  localparam int IDX_W  = ADDR_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_INPUTS - 1);
  localparam logic [7:0]       HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  typedef enum logic [0:0] {FILL, WAIT_SWAP} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] bank [2][N_INPUTS];
  logic [IDX_W-1:0]  idx;
  logic              wr_bank, rd_bank;
  logic [7:0]        hold_cnt;
  logic              at_last, store, swap, drop;

  assign at_last = (idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  // s_last must coincide exactly with the final slot; any mismatch drops the word
  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    store     = 1'b0;
    swap      = 1'b0;
    drop      = 1'b0;
    case (state)
      FILL: begin
        s_ready = !rst;
        if (s_valid && !rst) begin
          if (s_last != at_last) begin
            drop = 1'b1;
          end else begin
            store = 1'b1;
            if (s_last) begin
              if (hold_cnt == 8'd0) swap = 1'b1;
              else                  state_nxt = WAIT_SWAP;
            end
          end
        end
      end
      WAIT_SWAP: begin
        if (hold_cnt == 8'd0) begin
          swap      = 1'b1;
          state_nxt = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < N_INPUTS; i++) begin
          bank[b][i] <= '0;
        end
      end
      idx       <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b1;
      hold_cnt  <= 8'd0;
      vec_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      vec_valid <= swap;
      frame_err <= drop;
      if (hold_cnt != 8'd0) hold_cnt <= hold_cnt - 8'd1;
      if (store) begin
        bank[wr_bank][idx[ADDR_W-1:0]] <= s_data;
        if (!s_last) idx <= idx + 1'b1;
      end
      if (drop) idx <= '0;
      if (swap) begin
        rd_bank  <= wr_bank;
        wr_bank  <= ~wr_bank;
        idx      <= '0;
        hold_cnt <= HOLD_LOAD;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_INPUTS; i++) begin
      vec_out[i] = bank[rd_bank][i];
    end
  end

endmodule

// File: tb/tb_neuron_vector_loader.sv
// tb/tb_neuron_vector_loader.sv - self-checking bench for neuron_vector_loader
module tb_neuron_vector_loader;

  localparam int NA   = 37;
  localparam int NB   = 4;
  localparam int HOLD = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i [2];
  logic        sv_i  [2];
  logic [31:0] sd_i  [2];
  logic        sl_i  [2];
  logic        rdy_o [2];
  logic        vv_o  [2];
  logic        fe_o  [2];
  logic [31:0] vo_a  [NA];
  logic [31:0] vo_b  [NB];

  neuron_vector_loader #(.N_INPUTS(NA), .DATA_W(32), .HOLD_CYCLES(HOLD)) dut_a (
    .clk(clk), .rst(rst_i[0]), .s_valid(sv_i[0]), .s_ready(rdy_o[0]),
    .s_data(sd_i[0]), .s_last(sl_i[0]), .vec_out(vo_a), .vec_valid(vv_o[0]),
    .frame_err(fe_o[0])
  );

  neuron_vector_loader #(.N_INPUTS(NB), .DATA_W(32), .HOLD_CYCLES(HOLD)) dut_b (
    .clk(clk), .rst(rst_i[1]), .s_valid(sv_i[1]), .s_ready(rdy_o[1]),
    .s_data(sd_i[1]), .s_last(sl_i[1]), .vec_out(vo_b), .vec_valid(vv_o[1]),
    .frame_err(fe_o[1])
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: frames as word lists, swap time = max(completion, last swap + HOLD)
  logic [31:0] obs   [2][NA];
  logic [31:0] cur   [2][NA];
  logic [31:0] pend  [2][NA];
  logic [31:0] shown [2][NA];
  int cur_n [2];
  bit pend_v [2];
  bit started [2];
  bit exp_vv [2];
  bit exp_fe [2];
  int last_swap [2];
  int vv_count [2];
  int fe_count [2];
  int vv_cyc [2];
  int prev_vv_cyc [2];
  int acc_cyc [2];
  int rdy_low [2];

  logic [31:0] fbuf [NA+1];
  logic [31:0] ref_vec [NA];

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cyc=%0d got=%h expected=%h", name, d, cyc, act, exp);
    end
  endtask

  task automatic model_step(input int d);
    int n;
    int mism;
    n = (d == 0) ? NA : NB;
    if (started[d]) begin
      chk("s_ready", d, 32'(rdy_o[d]), 32'(!rst_i[d] && !pend_v[d]));
      chk("vec_valid", d, 32'(vv_o[d]), 32'(exp_vv[d]));
      chk("frame_err", d, 32'(fe_o[d]), 32'(exp_fe[d]));
      mism = 0;
      for (int i = 0; i < n; i++) if (obs[d][i] !== shown[d][i]) mism++;
      chk("vec_out_mismatches", d, 32'(mism), 32'd0);
      if (vv_o[d] === 1'b1) begin
        prev_vv_cyc[d] = vv_cyc[d];
        vv_cyc[d] = cyc;
        vv_count[d]++;
      end
      if (fe_o[d] === 1'b1) fe_count[d]++;
      if (!rst_i[d] && rdy_o[d] !== 1'b1) rdy_low[d]++;
    end
    if (rst_i[d]) begin
      started[d] = 1'b1;
      cur_n[d] = 0;
      pend_v[d] = 1'b0;
      exp_vv[d] = 1'b0;
      exp_fe[d] = 1'b0;
      last_swap[d] = -1000;
      for (int i = 0; i < NA; i++) shown[d][i] = 32'h0;
    end else if (started[d]) begin
      exp_vv[d] = 1'b0;
      exp_fe[d] = 1'b0;
      if (sv_i[d] && !pend_v[d]) begin
        acc_cyc[d] = cyc;
        if (sl_i[d] != (cur_n[d] == n - 1)) begin
          exp_fe[d] = 1'b1;
          cur_n[d] = 0;
        end else begin
          cur[d][cur_n[d]] = sd_i[d];
          cur_n[d]++;
          if (sl_i[d]) begin
            for (int i = 0; i < n; i++) pend[d][i] = cur[d][i];
            pend_v[d] = 1'b1;
            cur_n[d] = 0;
          end
        end
      end
      if (pend_v[d] && (cyc - last_swap[d] >= HOLD)) begin
        for (int i = 0; i < n; i++) shown[d][i] = pend[d][i];
        pend_v[d] = 1'b0;
        exp_vv[d] = 1'b1;
        last_swap[d] = cyc;
      end
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < NA; i++) obs[0][i] = vo_a[i];
    for (int i = 0; i < NB; i++) obs[1][i] = vo_b[i];
    model_step(0);
    model_step(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int d, input int k);
    sv_i[d] = 1'b0;
    repeat (k) tick();
  endtask

  task automatic send_word(input int d, input logic [31:0] w, input logic l, input int gap_pct);
    bit got;
    int budget;
    while ($urandom_range(99) < gap_pct) begin
      sv_i[d] = 1'b0;
      tick();
    end
    sv_i[d] = 1'b1;
    sd_i[d] = w;
    sl_i[d] = l;
    got = 1'b0;
    budget = 0;
    while (!got) begin
      @(negedge clk);
      got = (rdy_o[d] === 1'b1);
      tick();
      budget++;
      if (!got && budget > 100) begin
        chk("accept_timeout", d, 32'd0, 32'd1);
        got = 1'b1;
      end
    end
    sv_i[d] = 1'b0;
  endtask

  task automatic send_frame(input int d, input int len, input int gap_pct, input logic last_on_final);
    for (int i = 0; i < len; i++) send_word(d, fbuf[i], (i == len - 1) ? last_on_final : 1'b0, gap_pct);
  endtask

  function automatic logic [31:0] f32_int(input int v);
    int e;
    e = 0;
    while ((v >> (e + 1)) != 0) e++;
    return (32'(127 + e) << 23) | ((32'(v) << (23 - e)) & 32'h007F_FFFF);
  endfunction

  typedef struct {
    logic        rst;
    logic        sv;
    logic [31:0] sd;
    logic        sl;
    logic        rdy;
    logic        vv;
    logic        fe;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic v, input logic [31:0] d, input logic l,
                              input logic rd, input logic vv, input logic fe);
    vec_t t;
    t.rst = r; t.sv = v; t.sd = d; t.sl = l; t.rdy = rd; t.vv = vv; t.fe = fe;
    return t;
  endfunction

  vec_t tbl [18];

  initial begin
    #500000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int vv0, fe0, rl0, mism, n, len, r;

    tbl[0]  = mk(1, 0, 32'h0,        0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 32'h7FC00001, 0, 1, 0, 0);
    tbl[2]  = mk(0, 1, 32'h00000001, 0, 1, 0, 0);
    tbl[3]  = mk(0, 1, 32'h80000000, 0, 1, 0, 0);
    tbl[4]  = mk(0, 1, 32'hFF800000, 1, 1, 0, 0);
    tbl[5]  = mk(0, 1, 32'h3F800000, 0, 1, 1, 0);
    tbl[6]  = mk(0, 1, 32'hC0490FDB, 0, 1, 0, 0);
    tbl[7]  = mk(0, 1, 32'h007FFFFF, 0, 1, 0, 0);
    tbl[8]  = mk(0, 1, 32'h7F7FFFFF, 1, 1, 0, 0);
    tbl[9]  = mk(0, 1, 32'h11111111, 0, 0, 0, 0);
    tbl[10] = mk(0, 1, 32'h11111111, 0, 0, 0, 0);
    tbl[11] = mk(0, 1, 32'h11111111, 0, 0, 0, 0);
    tbl[12] = mk(0, 1, 32'h11111111, 0, 0, 0, 0);
    tbl[13] = mk(0, 1, 32'h11111111, 0, 1, 1, 0);
    tbl[14] = mk(0, 1, 32'h22222222, 0, 1, 0, 0);
    tbl[15] = mk(0, 1, 32'h33333333, 1, 1, 0, 0);
    tbl[16] = mk(0, 0, 32'h0,        0, 1, 0, 1);
    tbl[17] = mk(0, 0, 32'h0,        0, 1, 0, 0);

    for (int d = 0; d < 2; d++) begin
      rst_i[d] = 1'b1;
      sv_i[d] = 1'b0;
      sd_i[d] = 32'h0;
      sl_i[d] = 1'b0;
    end
    tick();
    tick();
    rst_i[0] = 1'b0;
    rst_i[1] = 1'b0;
    tick();

    // 1: single ramp vector 1.0 .. 37.0
    vv0 = vv_count[0];
    rl0 = rdy_low[0];
    for (int i = 0; i < NA; i++) fbuf[i] = f32_int(i + 1);
    send_frame(0, NA, 0, 1'b1);
    idle(0, 3);
    chk("t1_vv_pulses", 0, 32'(vv_count[0] - vv0), 32'd1);
    chk("t1_latency", 0, 32'(vv_cyc[0] - acc_cyc[0]), 32'd1);
    chk("t1_elem0", 0, vo_a[0], 32'h3F800000);
    chk("t1_elem36", 0, vo_a[36], 32'h42140000);
    chk("t1_ready_drops", 0, 32'(rdy_low[0] - rl0), 32'd0);

    // 2: two back-to-back vectors
    vv0 = vv_count[0];
    rl0 = rdy_low[0];
    for (int i = 0; i < NA; i++) fbuf[i] = $urandom;
    send_frame(0, NA, 0, 1'b1);
    for (int i = 0; i < NA; i++) begin
      fbuf[i] = $urandom;
      ref_vec[i] = fbuf[i];
    end
    send_frame(0, NA, 0, 1'b1);
    idle(0, 3);
    chk("t2_vv_pulses", 0, 32'(vv_count[0] - vv0), 32'd2);
    chk("t2_vv_spacing", 0, 32'(vv_cyc[0] - prev_vv_cyc[0]), 32'(NA));
    chk("t2_ready_drops", 0, 32'(rdy_low[0] - rl0), 32'd0);
    chk("t2_elem0", 0, vo_a[0], ref_vec[0]);
    chk("t2_elem36", 0, vo_a[36], ref_vec[36]);

    // 3: N_INPUTS=4 hold back-pressure, cycle-exact table
    for (int t = 0; t < 18; t++) begin
      rst_i[1] = tbl[t].rst;
      sv_i[1]  = tbl[t].sv;
      sd_i[1]  = tbl[t].sd;
      sl_i[1]  = tbl[t].sl;
      @(negedge clk);
      chk("t3_s_ready", 1, 32'(rdy_o[1]), 32'(tbl[t].rdy));
      chk("t3_vec_valid", 1, 32'(vv_o[1]), 32'(tbl[t].vv));
      chk("t3_frame_err", 1, 32'(fe_o[1]), 32'(tbl[t].fe));
      tick();
    end
    sv_i[1] = 1'b0;
    chk("t3_elem0", 1, vo_b[0], 32'h3F800000);
    chk("t3_elem1", 1, vo_b[1], 32'hC0490FDB);
    chk("t3_elem2", 1, vo_b[2], 32'h007FFFFF);
    chk("t3_elem3", 1, vo_b[3], 32'h7F7FFFFF);

    // 4: early s_last on word 10, then a good frame
    vv0 = vv_count[0];
    fe0 = fe_count[0];
    for (int i = 0; i < NA; i++) fbuf[i] = $urandom;
    send_frame(0, 10, 0, 1'b1);
    idle(0, 3);
    chk("t4_fe_pulses", 0, 32'(fe_count[0] - fe0), 32'd1);
    chk("t4_no_vv", 0, 32'(vv_count[0] - vv0), 32'd0);
    chk("t4_vec_kept", 0, vo_a[0], ref_vec[0]);
    for (int i = 0; i < NA; i++) fbuf[i] = $urandom;
    send_frame(0, NA, 0, 1'b1);
    idle(0, 3);
    chk("t4_vv_pulses", 0, 32'(vv_count[0] - vv0), 32'd1);
    chk("t4_elem0", 0, vo_a[0], fbuf[0]);
    chk("t4_elem36", 0, vo_a[36], fbuf[36]);

    // 5: missing s_last, then a lone s_last word
    vv0 = vv_count[0];
    fe0 = fe_count[0];
    for (int i = 0; i < NA; i++) fbuf[i] = $urandom;
    send_frame(0, NA, 0, 1'b0);
    idle(0, 2);
    chk("t5_fe_first", 0, 32'(fe_count[0] - fe0), 32'd1);
    send_word(0, $urandom, 1'b1, 0);
    idle(0, 3);
    chk("t5_fe_second", 0, 32'(fe_count[0] - fe0), 32'd2);
    chk("t5_no_vv", 0, 32'(vv_count[0] - vv0), 32'd0);

    // 6: reset mid-frame, then gappy vs gapless streams of the same vector
    for (int i = 0; i < NA; i++) fbuf[i] = $urandom;
    send_frame(0, 20, 0, 1'b0);
    rst_i[0] = 1'b1;
    @(negedge clk);
    chk("t6_ready_in_reset", 0, 32'(rdy_o[0]), 32'd0);
    tick();
    rst_i[0] = 1'b0;
    @(negedge clk);
    chk("t6_ready_after_reset", 0, 32'(rdy_o[0]), 32'd1);
    chk("t6_zero_elem0", 0, vo_a[0], 32'h0);
    chk("t6_zero_elem36", 0, vo_a[36], 32'h0);
    tick();
    vv0 = vv_count[0];
    for (int i = 0; i < NA; i++) begin
      fbuf[i] = $urandom;
      ref_vec[i] = fbuf[i];
    end
    send_frame(0, NA, 50, 1'b1);
    idle(0, 3);
    chk("t6_vv_gappy", 0, 32'(vv_count[0] - vv0), 32'd1);
    mism = 0;
    for (int i = 0; i < NA; i++) if (vo_a[i] !== ref_vec[i]) mism++;
    chk("t6_gappy_vec", 0, 32'(mism), 32'd0);
    send_frame(0, NA, 0, 1'b1);
    idle(0, 3);
    mism = 0;
    for (int i = 0; i < NA; i++) if (vo_a[i] !== ref_vec[i]) mism++;
    chk("t6_gapless_vec", 0, 32'(mism), 32'd0);

    // random frames, framing errors, gaps and resets against the model
    for (int d = 0; d < 2; d++) begin
      n = (d == 0) ? NA : NB;
      for (int f = 0; f < ((d == 0) ? 25 : 120); f++) begin
        r = int'($urandom_range(9));
        if (r == 0) begin
          rst_i[d] = 1'b1;
          tick();
          rst_i[d] = 1'b0;
        end
        len = (r == 1) ? int'($urandom_range(1, n + 1)) : n;
        for (int i = 0; i < len; i++) fbuf[i] = $urandom;
        send_frame(d, len, (r < 5) ? 30 : 0, 1'b1);
      end
      idle(d, HOLD + 3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
